pe_output_sched: RTL and testbench
==================================

# pe_output_sched

Ejection-port scheduler for the router's PE output. It shares the single PE output link between the cw and ccw input channels on both virtual channels (even, odd). For each VC it runs a grant/capture/send handshake. Each VC is served only in its polarity phase: even when `polarity`=0, odd when `polarity`=1. It sits between the cw/ccw input buffers and the PE interface, in the same way the ring output blocks sit in front of their links.

## Interface
- `DATA_WIDTH`, 64, packet width.
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `polarity`  in  1  link phase; 0 = even VC eligible, 1 = odd VC eligible.
- `peri`  in  1  PE ready to accept a packet.
- `request_cw_even`, `request_cw_odd`, `request_ccw_even`, `request_ccw_odd`  in  1 each  input buffer holds a packet for the PE on that VC.
- `data_in_cw_even`, `data_in_cw_odd`, `data_in_ccw_even`, `data_in_ccw_odd`  in  DATA_WIDTH each  head packet of the corresponding buffer.
- `grant_cw_even`, `grant_cw_odd`, `grant_ccw_even`, `grant_ccw_odd`  out  1 each  registered one-cycle grant; the buffer pops on it.
- `peso`  out  1  registered send strobe, one cycle per packet.
- `pedo`  out  DATA_WIDTH  packet to PE, passed unmodified (no hop edit).

## Operation
- Two independent per-VC FSMs, identical except for the eligibility phase. Each has a DATA_WIDTH holding register and a winner pointer `last_ccw_v`.
- **IDLE**:
  - If either request on VC v is high, pick the winner, register it, and go to GRANT.
  - If neither is high, stay in IDLE.
  - Winner selection: a lone requester wins. If both request, the winner is set by the fairness rule (see Configuration).
- **GRANT** (exactly one cycle):
  - The winner's grant is high.
  - At the closing edge, the holding register captures the winner's `data_in`.
  - `last_ccw_v` is set to 1 if ccw won, 0 if cw won.
  - Next state is HOLD.
  - Requests are ignored in GRANT and HOLD. The requester must drop or refresh its request after seeing the grant.
- **HOLD**:
  - If `peri`=1 and `polarity` equals the VC (even: 0, odd: 1), at that edge `pedo` <= holding register, `peso` <= 1, and the FSM goes to IDLE.
  - Otherwise it stays in HOLD with the holding register stable.
- **Output mux:** only one VC can be eligible in a given cycle, so the two sends never collide. If neither VC sends, `peso` <= 0 and `pedo` holds its value.
- **Reset (asynchronous)** forces the following immediately, including mid-handshake:
  - Both FSMs to IDLE, both holding registers to 0, `last_ccw_v` to 1 (cw favoured first).
  - All grants 0, `peso` 0, `pedo` 0.
  - A packet already granted but not yet sent is discarded.

## Timing
- With a request high before edge E0 in IDLE:
  - Grant is high from E0 to E1.
  - Data is captured at E1, so `data_in` must be valid through E1.
  - Earliest send is at E2, giving `peso` high from E2 to E3.
  - Minimum request-to-`peso` latency is 2 cycles.
- Per-VC throughput: at most one packet every 3 cycles. The two VCs overlap, so link throughput is higher.
- `peso` is never high in two consecutive cycles for the same VC.
- A `peri` drop in HOLD stalls the FSM indefinitely, with no loss and no duplicate.
- A `polarity` change during GRANT has no effect; only HOLD is phase-gated.

## Configuration
- `PE_OUT_RR_EN` defined: round-robin on contention.
  - When both request on VC v, ccw wins if `last_ccw_v`=0, otherwise cw wins.
  - Each VC keeps its own pointer.
- `PE_OUT_RR_EN` undefined: fixed priority, cw always wins contention.
  - The pointer register is still updated but unused.
  - Sustained cw traffic may starve ccw; this is accepted.

## Test plan
- **Single cw even request:** `request_cw_even`=1 with data 0x0A, `polarity`=0 at send time, `peri`=1.
  - `grant_cw_even` is high one cycle.
  - `peso` is high 2 cycles after the request is sampled, with `pedo`=0x0A.
- **Contention, RR enabled:** cw and ccw even both request continuously (data 0x11, 0x22), `peri`=1, `polarity` toggling each cycle.
  - Grants alternate cw, ccw, cw.
  - `pedo` sequence is 0x11, 0x22, 0x11.
- **Contention, RR disabled:** same stimulus as above.
  - Only `grant_cw_even` fires.
  - `pedo` is always 0x11.
- **Backpressure and phase gating:** `request_ccw_odd`=1 with data 0x33, `peri`=0 for 5 cycles.
  - No `peso`, and the holding register stays at 0x33.
  - After `peri`=1, `peso` fires on the first edge with `polarity`=1, exactly once.
- **Reset mid-operation:** assert `rst` while an FSM is in HOLD.
  - All outputs go to 0 immediately.
  - After release with no requests, `peso` stays 0 indefinitely.

Source files
------------

// File: rtl/pe_output_sched.sv
// pe_output_sched
//   Ejection-port scheduler. The single PE output link is shared between the
//   cw and ccw input channels on two virtual channels (even, odd). Each VC
//   runs its own grant -> capture -> send handshake. A VC may send only in its
//   polarity phase: even when polarity=0, odd when polarity=1.
//
//   Per-VC handshake:
//     IDLE  : a request on the VC picks a winner and registers its grant
//     GRANT : grant high for one cycle; the winner's data is captured at the
//             closing edge and the winner pointer is updated
//     HOLD  : waits for peri=1 in the VC's phase, then drives pedo/peso
//
// Configuration:
//   PE_OUT_RR_EN  defined   -> round-robin between cw/ccw on contention
//                 undefined -> fixed priority, cw always wins contention
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   polarity                     link phase (0 = even VC eligible, 1 = odd)
//   peri                         PE ready to accept a packet
//   request_{cw,ccw}_{even,odd}  buffer holds a packet for the PE on that VC
//   data_in_{cw,ccw}_{even,odd}  head packet of the corresponding buffer
//   grant_{cw,ccw}_{even,odd}    registered one-cycle grant (buffer pops)
//   peso                         registered send strobe, one cycle per packet
//   pedo                         packet to the PE, passed unmodified
module pe_output_sched #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  peri,
  input  logic                  request_cw_even,
  input  logic                  request_cw_odd,
  input  logic                  request_ccw_even,
  input  logic                  request_ccw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_cw_even,
  input  logic [DATA_WIDTH-1:0] data_in_cw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_even,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_odd,
  output logic                  grant_cw_even,
  output logic                  grant_cw_odd,
  output logic                  grant_ccw_even,
  output logic                  grant_ccw_odd,
  output logic                  peso,
  output logic [DATA_WIDTH-1:0] pedo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Index 0 = even VC, index 1 = odd VC.
  logic [1:0]            req_cw;
  logic [1:0]            req_ccw;
  logic [DATA_WIDTH-1:0] din_cw   [2];
  logic [DATA_WIDTH-1:0] din_ccw  [2];
  logic [1:0]            grant_cw;
  logic [1:0]            grant_ccw;
  logic [1:0]            send;
  logic [DATA_WIDTH-1:0] hold_q   [2];

  assign req_cw     = {request_cw_odd,  request_cw_even};
  assign req_ccw    = {request_ccw_odd, request_ccw_even};
  assign din_cw[0]  = data_in_cw_even;
  assign din_cw[1]  = data_in_cw_odd;
  assign din_ccw[0] = data_in_ccw_even;
  assign din_ccw[1] = data_in_ccw_odd;

  assign grant_cw_even  = grant_cw[0];
  assign grant_cw_odd   = grant_cw[1];
  assign grant_ccw_even = grant_ccw[0];
  assign grant_ccw_odd  = grant_ccw[1];

  for (genvar v = 0; v < 2; v++) begin : g_vc
    localparam logic VC_PHASE = (v == 1);

    state_t state_q;
    state_t state_d;
    logic   win_ccw_q;
    logic   win_ccw_d;
    logic   last_ccw_q;
    logic   pick_ccw;

`ifdef PE_OUT_RR_EN
    // ccw wins a tie only if cw won the previous handshake on this VC.
    assign pick_ccw = req_ccw[v] & (~req_cw[v] | ~last_ccw_q);
`else
    // cw always wins a tie; the pointer is still tracked but not consulted.
    assign pick_ccw = req_ccw[v] & ~req_cw[v];
    logic unused_last_ccw;
    assign unused_last_ccw = last_ccw_q;
`endif

    always_comb begin
      state_d   = state_q;
      win_ccw_d = win_ccw_q;
      send[v]   = 1'b0;
      case (state_q)
        IDLE: begin
          if (req_cw[v] | req_ccw[v]) begin
            win_ccw_d = pick_ccw;
            state_d   = GRANT;
          end
        end
        GRANT: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (peri && (polarity == VC_PHASE)) begin
            send[v] = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q      <= IDLE;
        win_ccw_q    <= 1'b0;
        last_ccw_q   <= 1'b1;
        hold_q[v]    <= '0;
        grant_cw[v]  <= 1'b0;
        grant_ccw[v] <= 1'b0;
      end else begin
        state_q   <= state_d;
        win_ccw_q <= win_ccw_d;
        // GRANT is entered only from IDLE, so this is a one-cycle pulse.
        grant_cw[v]  <= (state_d == GRANT) & ~win_ccw_d;
        grant_ccw[v] <= (state_d == GRANT) &  win_ccw_d;
        if (state_q == GRANT) begin
          hold_q[v]  <= win_ccw_q ? din_ccw[v] : din_cw[v];
          last_ccw_q <= win_ccw_q;
        end
      end
    end
  end

  // Output mux: the phases are exclusive, so at most one VC sends per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peso <= 1'b0;
      pedo <= '0;
    end else begin
      peso <= |send;
      if (send[0]) begin
        pedo <= hold_q[0];
      end else if (send[1]) begin
        pedo <= hold_q[1];
      end
    end
  end

endmodule

// File: tb/tb_pe_output_sched.sv
module tb_pe_output_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        polarity = 1'b0;
  logic        peri = 1'b0;
  logic        request_cw_even = 1'b0, request_cw_odd = 1'b0;
  logic        request_ccw_even = 1'b0, request_ccw_odd = 1'b0;
  logic [63:0] data_in_cw_even = '0, data_in_cw_odd = '0;
  logic [63:0] data_in_ccw_even = '0, data_in_ccw_odd = '0;
  logic        grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd;
  logic        peso;
  logic [63:0] pedo;

  int vectors = 0;
  int miscompares = 0;

  pe_output_sched #(.DATA_WIDTH(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .polarity        (polarity),
    .peri            (peri),
    .request_cw_even (request_cw_even),
    .request_cw_odd  (request_cw_odd),
    .request_ccw_even(request_ccw_even),
    .request_ccw_odd (request_ccw_odd),
    .data_in_cw_even (data_in_cw_even),
    .data_in_cw_odd  (data_in_cw_odd),
    .data_in_ccw_even(data_in_ccw_even),
    .data_in_ccw_odd (data_in_ccw_odd),
    .grant_cw_even   (grant_cw_even),
    .grant_cw_odd    (grant_cw_odd),
    .grant_ccw_even  (grant_ccw_even),
    .grant_ccw_odd   (grant_ccw_odd),
    .peso            (peso),
    .pedo            (pedo)
  );

  always #5 clk = ~clk;

  // Reference model: each VC holds at most one packet in flight, described by
  // how many edges have passed since it was granted (0 = nothing in flight).
  int          age   [2];
  bit          m_ccw [2];   // in-flight packet came from ccw
  bit          m_last[2];   // previous winner was ccw
  logic [63:0] m_pkt [2];
  bit          m_gcw [2];
  bit          m_gccw[2];
  bit          m_peso;
  logic [63:0] m_pedo;
  int          sends;

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      age[v] = 0; m_ccw[v] = 0; m_last[v] = 1; m_pkt[v] = '0;
      m_gcw[v] = 0; m_gccw[v] = 0;
    end
    m_peso = 0; m_pedo = '0;
  endtask

  task automatic model_edge();
    bit          rc, rq, ccw_wins;
    logic [63:0] dc, dq;
    bit          n_peso;
    logic [63:0] n_pedo;
    n_peso = 0;
    n_pedo = m_pedo;
    for (int v = 0; v < 2; v++) begin
      rc = (v == 0) ? request_cw_even  : request_cw_odd;
      rq = (v == 0) ? request_ccw_even : request_ccw_odd;
      dc = (v == 0) ? data_in_cw_even  : data_in_cw_odd;
      dq = (v == 0) ? data_in_ccw_even : data_in_ccw_odd;
      m_gcw[v] = 0; m_gccw[v] = 0;
      if (age[v] == 0) begin
        if (rc || rq) begin
`ifdef PE_OUT_RR_EN
          ccw_wins = rq && (!rc || !m_last[v]);
`else
          ccw_wins = rq && !rc;
`endif
          m_ccw[v] = ccw_wins;
          m_gcw[v] = !ccw_wins;
          m_gccw[v] = ccw_wins;
          age[v] = 1;
        end
      end else if (age[v] == 1) begin
        m_pkt[v] = m_ccw[v] ? dq : dc;
        m_last[v] = m_ccw[v];
        age[v] = 2;
      end else if (peri && (polarity == (v == 1))) begin
        n_peso = 1;
        n_pedo = m_pkt[v];
        age[v] = 0;
      end
    end
    m_peso = n_peso;
    m_pedo = n_pedo;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("grant_cw_even",  {63'd0, grant_cw_even},  {63'd0, m_gcw[0]});
    check("grant_cw_odd",   {63'd0, grant_cw_odd},   {63'd0, m_gcw[1]});
    check("grant_ccw_even", {63'd0, grant_ccw_even}, {63'd0, m_gccw[0]});
    check("grant_ccw_odd",  {63'd0, grant_ccw_odd},  {63'd0, m_gccw[1]});
    check("peso", {63'd0, peso}, {63'd0, m_peso});
    check("pedo", pedo, m_pedo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    if (m_peso) sends++;
    #1;
    check_all();
  endtask

  task automatic set_req(input bit ce, input bit co, input bit qe, input bit qo);
    request_cw_even = ce; request_cw_odd = co;
    request_ccw_even = qe; request_ccw_odd = qo;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grants"}, {60'd0, grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd}, 64'd0);
    check({tag, "_peso"}, {63'd0, peso}, 64'd0);
    check({tag, "_pedo"}, pedo, 64'd0);
  endtask

  initial begin
    model_reset();
    sends = 0;

    // Reset state.
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single cw even request, data 0x0A.
    polarity = 1'b0; peri = 1'b1;
    data_in_cw_even = 64'h0A;
    set_req(1, 0, 0, 0);
    tick();                                   // E0: grant
    check("single_grant", {63'd0, grant_cw_even}, 64'd1);
    set_req(0, 0, 0, 0);
    tick();                                   // E1: capture
    tick();                                   // E2: send
    check("single_peso", {63'd0, peso}, 64'd1);
    check("single_pedo", pedo, 64'h0A);
    tick();
    check("single_peso_once", {63'd0, peso}, 64'd0);

    // Contention on even VC, polarity toggling every cycle.
    data_in_cw_even = 64'h11; data_in_ccw_even = 64'h22;
    set_req(1, 0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      tick();
      polarity = ~polarity;
    end
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    // Backpressure: ccw odd 0x33, peri low for 5 cycles.
    peri = 1'b0;
    data_in_ccw_odd = 64'h33;
    set_req(0, 0, 0, 1);
    tick();
    set_req(0, 0, 0, 0);
    sends = 0;
    for (int i = 0; i < 5; i++) begin
      polarity = 1'($urandom_range(0, 1));
      tick();
    end
    check("bp_no_send", sends, 0);
    peri = 1'b1;
    polarity = 1'b0;
    tick();
    polarity = 1'b1;
    tick();
    check("bp_pedo", pedo, 64'h33);
    for (int i = 0; i < 4; i++) tick();
    check("bp_sends_once", sends, 1);

    // Reset while the odd VC is in HOLD.
    peri = 1'b0;
    data_in_cw_odd = 64'h44;
    set_req(0, 1, 0, 0);
    tick();
    set_req(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    #2;
    rst = 1'b0;
    peri = 1'b1;
    sends = 0;
    for (int i = 0; i < 10; i++) begin
      polarity = 1'($urandom_range(0, 1));
      tick();
    end
    check("post_rst_idle", sends, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      set_req(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      data_in_cw_even  = {$urandom, $urandom};
      data_in_cw_odd   = {$urandom, $urandom};
      data_in_ccw_even = {$urandom, $urandom};
      data_in_ccw_odd  = {$urandom, $urandom};
      peri     = ($urandom_range(0, 3) != 0);
      polarity = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
